mpsoc_glip_channel_arbiter: RTL and testbench

//  Packet-aware N:1 arbiter merging NUM_CH debug/host GLIP lanes (one per tile or debug subnet) into one

---
 rtl/mpsoc_glip_arb_pkg.sv | 16 +
 rtl/mpsoc_glip_lane_fifo.sv | 47 ++++
 rtl/mpsoc_glip_channel_arbiter.sv | 149 ++++++++++++++
 tb/tb_mpsoc_glip_channel_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mpsoc_glip_arb_pkg.sv
// Shared types, defaults and helpers for the GLIP channel arbiter.
// Optional statistics are enabled with MPSOC_GLIP_ARB_STATS_EN.
package mpsoc_glip_arb_pkg;

  typedef enum logic {IDLE, BURST} state_t;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_WIDTH       = 16;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_MAX_PKT_LEN = 12;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mpsoc_glip_lane_fifo.sv
// First-word-fall-through lane FIFO; head word is visible combinationally.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module mpsoc_glip_lane_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // A full FIFO refuses a push even when it is popped in the same cycle.
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mpsoc_glip_channel_arbiter.sv
// Packet-aware round-robin N:1 GLIP merger with per-lane FIFOs and runaway truncation.
// Define MPSOC_GLIP_ARB_STATS_EN to add saturating beat/truncation counters.
module mpsoc_glip_channel_arbiter
  import mpsoc_glip_arb_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
  localparam int CH_W       = ch_w(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0][WIDTH-1:0]   in_data,
  input  logic [NUM_CH-1:0]              in_last,
  input  logic [NUM_CH-1:0]              in_valid,
  output logic [NUM_CH-1:0]              in_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_last,
  output logic [CH_W-1:0]                out_chan,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           err_trunc
`ifdef MPSOC_GLIP_ARB_STATS_EN
  ,
  output logic [NUM_CH-1:0][31:0]        stat_beats,
  output logic [15:0]                    stat_trunc
`endif
);

  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

  logic [NUM_CH-1:0]           full;
  logic [NUM_CH-1:0]           empty;
  logic [NUM_CH-1:0]           pop;
  logic [NUM_CH-1:0][WIDTH:0]  head_word;
  logic [NUM_CH-1:0]           head_last;
  logic [NUM_CH-1:0][WIDTH-1:0] head_data;

  state_t           state_reg, state_next;
  logic [CH_W-1:0]  grant_reg, grant_next;
  logic [CH_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic             err_trunc_reg, err_trunc_next;
  logic             pop_beat;
  logic             at_max;
  logic             found;
  logic [CH_W-1:0]  idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_lane
      mpsoc_glip_lane_fifo #(.WIDTH(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid[gi]),
        .push_data ({in_last[gi], in_data[gi]}),
        .pop       (pop[gi]),
        .head_data (head_word[gi]),
        .full      (full[gi]),
        .empty     (empty[gi])
      );
      assign in_ready[gi]  = !full[gi];
      assign head_last[gi] = head_word[gi][WIDTH];
      assign head_data[gi] = head_word[gi][WIDTH-1:0];
      assign pop[gi]       = pop_beat && (grant_reg == CH_W'(gi));
    end
  endgenerate

  assign at_max    = (beat_cnt_reg == CNT_W'(MAX_PKT_LEN - 1));
  assign out_chan  = grant_reg;
  assign err_trunc = err_trunc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= CH_W'(NUM_CH - 1);
      beat_cnt_reg  <= '0;
      err_trunc_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      beat_cnt_reg  <= beat_cnt_next;
      err_trunc_reg <= err_trunc_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    beat_cnt_next  = beat_cnt_reg;
    err_trunc_next = 1'b0;
    out_valid      = 1'b0;
    out_last       = 1'b0;
    out_data       = '0;
    pop_beat       = 1'b0;
    found          = 1'b0;
    idx            = '0;
    case (state_reg)
      IDLE: begin
        // Scan starts just after the last winner so every lane gets a turn.
        for (int k = 1; k <= NUM_CH; k++) begin
          idx = CH_W'((int'(rr_ptr_reg) + k) % NUM_CH);
          if (!found && !empty[idx]) begin
            found      = 1'b1;
            grant_next = idx;
          end
        end
        if (found) begin
          rr_ptr_next   = grant_next;
          beat_cnt_next = '0;
          state_next    = BURST;
        end
      end
      BURST: begin
        out_valid = !empty[grant_reg];
        if (out_valid) begin
          out_data = head_data[grant_reg];
          out_last = head_last[grant_reg] || at_max;
        end
        pop_beat = out_valid && out_ready;
        if (pop_beat) begin
          beat_cnt_next  = beat_cnt_reg + 1'b1;
          err_trunc_next = at_max && !head_last[grant_reg];
          if (out_last) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MPSOC_GLIP_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_beats <= '0;
      stat_trunc <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (pop[i] && (stat_beats[i] != 32'hFFFF_FFFF)) stat_beats[i] <= stat_beats[i] + 32'd1;
      end
      if (err_trunc_reg && (stat_trunc != 16'hFFFF)) stat_trunc <= stat_trunc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mpsoc_glip_channel_arbiter.sv
// Directed bench for the GLIP channel arbiter; expected values are hand-derived.
// Stats checks are compiled in when MPSOC_GLIP_ARB_STATS_EN is defined.
module tb_mpsoc_glip_channel_arbiter;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 16;
  localparam int CH_W   = 2;

  logic                         clk;
  logic                         rst;
  logic [NUM_CH-1:0][WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_last;
  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH-1:0]            in_ready;
  logic [WIDTH-1:0]             out_data;
  logic                         out_last;
  logic [CH_W-1:0]              out_chan;
  logic                         out_valid;
  logic                         out_ready;
  logic                         err_trunc;
`ifdef MPSOC_GLIP_ARB_STATS_EN
  logic [NUM_CH-1:0][31:0]      stat_beats;
  logic [15:0]                  stat_trunc;
`endif

  int checks   = 0;
  int failures = 0;

  mpsoc_glip_channel_arbiter #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(8), .MAX_PKT_LEN(12)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_trunc (err_trunc)
`ifdef MPSOC_GLIP_ARB_STATS_EN
    ,
    .stat_beats(stat_beats),
    .stat_trunc(stat_trunc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input int ch, input logic [15:0] d, input logic l, input logic v);
    in_data[ch]  = d;
    in_last[ch]  = l;
    in_valid[ch] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [15:0] obs_data [16];
  logic        obs_last [16];
  int          n;
  int          pulses;
  int          pulse_at;
  int          j;
  logic        pend_clear;

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst = 1'b0; out_ready = 1'b1;
    in_data = '0; in_last = '0; in_valid = '0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'hF);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    chk("rst_err_trunc", 32'(err_trunc), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Single lane 0, three-beat packet
    @(negedge clk); drive(0, 16'h0A, 1'b0, 1'b1);
    @(negedge clk); chk("t1_grant_gap", 32'(out_valid), 32'd0);
    drive(0, 16'h0B, 1'b0, 1'b1);
    @(negedge clk);
    chk("t1_b0_valid", 32'(out_valid), 32'd1);
    chk("t1_b0_data", 32'(out_data), 32'h0A);
    chk("t1_b0_chan", 32'(out_chan), 32'd0);
    chk("t1_b0_last", 32'(out_last), 32'd0);
    drive(0, 16'h0C, 1'b1, 1'b1);
    @(negedge clk); drive(0, 16'h00, 1'b0, 1'b0);
    chk("t1_b1_data", 32'(out_data), 32'h0B);
    chk("t1_b1_last", 32'(out_last), 32'd0);
    @(negedge clk);
    chk("t1_b2_data", 32'(out_data), 32'h0C);
    chk("t1_b2_last", 32'(out_last), 32'd1);
    @(negedge clk);
    chk("t1_idle", 32'(out_valid), 32'd0);

    // Four one-beat packets in the same cycle, fresh round-robin state
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) drive(i, 16'(16'h10 + i), 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = '0;
      chk("t2_valid", 32'(out_valid), 32'(k % 2));
      chk("t2_err", 32'(err_trunc), 32'd0);
      if (k % 2 == 1) begin
        chk("t2_chan", 32'(out_chan), 32'((k - 1) / 2));
        chk("t2_data", 32'(out_data), 32'(16'h10 + (k - 1) / 2));
      end
    end
    @(negedge clk);
    chk("t2_drained", 32'(out_valid), 32'd0);

    // Lane 2 runaway: 14 beats with no last, then a closing beat
    n = 0; pulses = 0; pulse_at = -1; j = 0;
    drive(2, 16'h20, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && n < 16) begin
        obs_data[n] = out_data;
        obs_last[n] = out_last;
        n++;
      end
      if (err_trunc) begin
        pulses++;
        pulse_at = n;
      end
      j++;
      if (j < 15) drive(2, 16'(16'h20 + j), (j == 14), 1'b1);
      else        drive(2, 16'h00, 1'b0, 1'b0);
    end
    chk("t3_count", 32'(n), 32'd15);
    for (int i = 0; i < 15; i++) begin
      chk("t3_data", 32'(obs_data[i]), 32'(16'h20 + i));
      chk("t3_last", 32'(obs_last[i]), 32'((i == 11) || (i == 14)));
    end
    chk("t3_pulses", 32'(pulses), 32'd1);
    chk("t3_pulse_at", 32'(pulse_at), 32'd12);

    // Lane 1 backpressure: fill the FIFO, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1, 16'(16'h40 + i), 1'b0, 1'b1);
    end
    @(negedge clk);
    chk("t4_full_ready", 32'(in_ready[1]), 32'd0);
    chk("t4_hold_valid", 32'(out_valid), 32'd1);
    chk("t4_hold_data", 32'(out_data), 32'h40);
    chk("t4_hold_chan", 32'(out_chan), 32'd1);
    drive(1, 16'h48, 1'b1, 1'b1);
    @(negedge clk);
    chk("t4_stable_data", 32'(out_data), 32'h40);
    chk("t4_still_full", 32'(in_ready[1]), 32'd0);
    out_ready = 1'b1;
    n = 0; pend_clear = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid && out_ready && n < 16) begin
        obs_data[n] = out_data;
        obs_last[n] = out_last;
        n++;
      end
      if (pend_clear) begin
        drive(1, 16'h00, 1'b0, 1'b0);
        pend_clear = 1'b0;
      end else if (in_valid[1] && in_ready[1]) begin
        pend_clear = 1'b1;
      end
      @(negedge clk);
    end
    chk("t4_count", 32'(n), 32'd9);
    for (int i = 0; i < 9; i++) begin
      chk("t4_data", 32'(obs_data[i]), 32'(16'h40 + i));
      chk("t4_last", 32'(obs_last[i]), 32'(i == 8));
    end

    // Reset mid-burst with three beats buffered on lane 3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3, 16'(16'h50 + i), 1'b0, 1'b1);
      @(negedge clk);
    end
    drive(3, 16'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    chk("t5_pre_chan", 32'(out_chan), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'hF);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    chk("t5_rst_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t5_no_stale", 32'(out_valid), 32'd0);
    end

`ifdef MPSOC_GLIP_ARB_STATS_EN
    // Statistics: lanes 0 and 1 send 5 and 7 beats
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 5) drive(0, 16'(16'h60 + i), (i == 4), 1'b1);
      else       drive(0, 16'h00, 1'b0, 1'b0);
      drive(1, 16'(16'h70 + i), (i == 6), 1'b1);
    end
    @(negedge clk);
    in_valid = '0;
    repeat (30) @(negedge clk);
    chk("st_beats0", stat_beats[0], 32'd5);
    chk("st_beats1", stat_beats[1], 32'd7);
    chk("st_trunc", 32'(stat_trunc), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
